// File: rtl/convertidor_bcd_a_temperatura.sv
// -----------------------------------------------------------------------------
// convertidor_bcd_a_temperatura
// Converts an operator-entered two-digit BCD temperature setpoint into the
// binary temperature code (value - TEMP_MIN). The conversion is sequential:
// digit check, tens*8, +tens*2, +units, then a range check. A start/valid
// handshake frames each request.
//
// Ports:
//   Clock                  system clock, all logic on the rising edge
//   Reset_n                synchronous active-low reset
//   Inicio                 conversion request, only taken while idle
//   Decenas_in             BCD tens digit, captured with Inicio
//   Unidades_in            BCD units digit, captured with Inicio
//   Ocupado                high while a conversion is in progress
//   Valido                 one-cycle pulse: result/error status updated
//   Temperatura_codificada last successfully converted code
//   Error                  1 when the last completed request was rejected
//   Codigo_error           00 ok, 01 non-BCD digit, 10 below min, 11 above max
// -----------------------------------------------------------------------------
module convertidor_bcd_a_temperatura #(
  parameter int TEMP_MIN = 20,
  parameter int ANCHO    = 5
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Inicio,
  input  logic [3:0]       Decenas_in,
  input  logic [3:0]       Unidades_in,
  output logic             Ocupado,
  output logic             Valido,
  output logic [ANCHO-1:0] Temperatura_codificada,
  output logic             Error,
  output logic [1:0]       Codigo_error
);

  localparam logic [2:0] REPOSO  = 3'd0;
  localparam logic [2:0] VALIDAR = 3'd1;
  localparam logic [2:0] MULT8   = 3'd2;
  localparam logic [2:0] MULT2   = 3'd3;
  localparam logic [2:0] SUMAR   = 3'd4;
  localparam logic [2:0] RANGO   = 3'd5;

  localparam logic [1:0] COD_OK   = 2'b00;
  localparam logic [1:0] COD_BCD  = 2'b01;
  localparam logic [1:0] COD_BAJO = 2'b10;
  localparam logic [1:0] COD_ALTO = 2'b11;

  // Range limits expressed in accumulator width (max 99 fits in 7 bits).
  localparam logic [6:0] TEMP_MIN_7 = 7'(TEMP_MIN);
  localparam logic [6:0] TEMP_MAX_7 = 7'(TEMP_MIN + (2 ** ANCHO) - 1);

  function automatic logic es_bcd(input logic [3:0] digito);
    return (digito <= 4'd9);
  endfunction

  logic [2:0]       estado_q,   estado_d;
  logic [3:0]       decenas_q,  decenas_d;
  logic [3:0]       unidades_q, unidades_d;
  logic [6:0]       acc_q,      acc_d;
  logic             ocupado_q,  ocupado_d;
  logic             valido_q,   valido_d;
  logic             error_q,    error_d;
  logic [1:0]       codigo_q,   codigo_d;
  logic [ANCHO-1:0] temp_q,     temp_d;
  logic [6:0]       diff_s;

  // Only meaningful in RANGO once the accumulator is known to be in range.
  assign diff_s = acc_q - TEMP_MIN_7;

  // Next-state and datapath logic of the conversion sequencer.
  always_comb begin
    estado_d   = estado_q;
    decenas_d  = decenas_q;
    unidades_d = unidades_q;
    acc_d      = acc_q;
    ocupado_d  = ocupado_q;
    valido_d   = 1'b0;
    error_d    = error_q;
    codigo_d   = codigo_q;
    temp_d     = temp_q;
    case (estado_q)
      REPOSO: begin
        if (Inicio) begin
          decenas_d  = Decenas_in;
          unidades_d = Unidades_in;
          ocupado_d  = 1'b1;
          estado_d   = VALIDAR;
        end else begin
          ocupado_d  = 1'b0;
        end
      end
      VALIDAR: begin
        if (!es_bcd(decenas_q) || !es_bcd(unidades_q)) begin
          // Early rejection: status updates, code is left untouched.
          error_d   = 1'b1;
          codigo_d  = COD_BCD;
          valido_d  = 1'b1;
          ocupado_d = 1'b0;
          estado_d  = REPOSO;
        end else begin
          estado_d  = MULT8;
        end
      end
      MULT8: begin
        acc_d    = {decenas_q, 3'b000};
        estado_d = MULT2;
      end
      MULT2: begin
        acc_d    = acc_q + {2'b00, decenas_q, 1'b0};
        estado_d = SUMAR;
      end
      SUMAR: begin
        acc_d    = acc_q + {3'b000, unidades_q};
        estado_d = RANGO;
      end
      RANGO: begin
        if (acc_q < TEMP_MIN_7) begin
          error_d  = 1'b1;
          codigo_d = COD_BAJO;
        end else if (acc_q > TEMP_MAX_7) begin
          error_d  = 1'b1;
          codigo_d = COD_ALTO;
        end else begin
          error_d  = 1'b0;
          codigo_d = COD_OK;
          temp_d   = diff_s[ANCHO-1:0];
        end
        valido_d  = 1'b1;
        ocupado_d = 1'b0;
        estado_d  = REPOSO;
      end
      default: begin
        ocupado_d = 1'b0;
        estado_d  = REPOSO;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      estado_q   <= REPOSO;
      decenas_q  <= 4'd0;
      unidades_q <= 4'd0;
      acc_q      <= 7'd0;
      ocupado_q  <= 1'b0;
      valido_q   <= 1'b0;
      error_q    <= 1'b0;
      codigo_q   <= COD_OK;
      temp_q     <= '0;
    end else begin
      estado_q   <= estado_d;
      decenas_q  <= decenas_d;
      unidades_q <= unidades_d;
      acc_q      <= acc_d;
      ocupado_q  <= ocupado_d;
      valido_q   <= valido_d;
      error_q    <= error_d;
      codigo_q   <= codigo_d;
      temp_q     <= temp_d;
    end
  end

  assign Ocupado                = ocupado_q;
  assign Valido                 = valido_q;
  assign Error                  = error_q;
  assign Codigo_error           = codigo_q;
  assign Temperatura_codificada = temp_q;

endmodule
